vga_timing_sequencer: RTL and testbench

//  Top-level VGA timing controller. Owns the horizontal (pixel) and vertical (line) counters and sequences them from a pixel-tick divider.

---
 rtl/vga_timing_sequencer.sv | 135 +++++++++++++
 tb/tb_vga_timing_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_sequencer.sv
//------------------------------------------------------------------------------
// Module  : vga_timing_sequencer
// Brief   : VGA pixel/line counters and four-phase sync FSMs, stepped by a pixel-tick divider.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing_sequencer #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clock,
    input  logic       Clear_n,
    input  logic       Enable,
    output logic       PixelTick,
    output logic [9:0] PixelX,
    output logic [9:0] PixelY,
    output logic       HSync,
    output logic       VSync,
    output logic       VideoOn,
    output logic       LineEnd,
    output logic       FrameStart
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FRONT_START = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BACK_START  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRONT_START = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BACK_START  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        PH_VISIBLE = 2'd0,
        PH_FRONT   = 2'd1,
        PH_SYNC    = 2'd2,
        PH_BACK    = 2'd3
    } phase_t;

    // Phase is a pure function of the counter, so state and count can never disagree.
    function automatic phase_t phase_of(
        input logic [9:0] cnt,
        input logic [9:0] front_start,
        input logic [9:0] sync_start,
        input logic [9:0] back_start
    );
        if (cnt < front_start)      return PH_VISIBLE;
        else if (cnt < sync_start)  return PH_FRONT;
        else if (cnt < back_start)  return PH_SYNC;
        else                        return PH_BACK;
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    phase_t           h_state_q, h_state_d;
    phase_t           v_state_q, v_state_d;
    logic             tick;
    logic             x_wrap;

    always_ff @(posedge Clock) begin
        if (!Clear_n) begin
            div_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            h_state_q <= PH_VISIBLE;
            v_state_q <= PH_VISIBLE;
        end else begin
            div_q     <= div_d;
            x_q       <= x_d;
            y_q       <= y_d;
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
        end
    end

    always_comb begin
        tick   = Enable && (div_q == DIV_MAX);
        x_wrap = (x_q == H_LAST);
        div_d  = div_q;
        x_d    = x_q;
        y_d    = y_q;

        if (Enable) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end

        if (tick) begin
            x_d = x_wrap ? '0 : x_q + 10'd1;
            if (x_wrap) begin
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end
        end

        h_state_d = phase_of(x_d, H_FRONT_START, H_SYNC_START, H_BACK_START);
        v_state_d = phase_of(y_d, V_FRONT_START, V_SYNC_START, V_BACK_START);
    end

    assign PixelTick  = tick;
    assign PixelX     = x_q;
    assign PixelY     = y_q;
    assign HSync      = (h_state_q != PH_SYNC);
    assign VSync      = (v_state_q != PH_SYNC);
    assign VideoOn    = (h_state_q == PH_VISIBLE) && (v_state_q == PH_VISIBLE);
    assign LineEnd    = tick && x_wrap;
    assign FrameStart = tick && x_wrap && (y_q == V_LAST);

`ifndef SYNTHESIS
    always_ff @(posedge Clock) begin
        if (Clear_n) begin
            assert (x_q <= H_LAST);
            assert (y_q <= V_LAST);
            assert (h_state_q == phase_of(x_q, H_FRONT_START, H_SYNC_START, H_BACK_START));
            assert (v_state_q == phase_of(y_q, V_FRONT_START, V_SYNC_START, V_BACK_START));
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_sequencer.sv
//------------------------------------------------------------------------------
// Module  : tb_vga_timing_sequencer
// Brief   : Scoreboard bench for vga_timing_sequencer using compact timing parameters.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_timing_sequencer;

    localparam int CD = 2;
    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic       clk = 1'b0;
    logic       Clear_n = 1'b0;
    logic       Enable = 1'b0;
    logic       PixelTick, HSync, VSync, VideoOn, LineEnd, FrameStart;
    logic [9:0] PixelX, PixelY;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_valid = 1'b0;
    int mdiv, mx, my;
    int m_fs_cnt = 0;
    int dut_fs_cnt = 0;

    logic [25:0] sb[$];

    always #5 clk = ~clk;

    vga_timing_sequencer #(
        .CLK_DIV  (CD),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) u_dut (
        .Clock     (clk),
        .Clear_n   (Clear_n),
        .Enable    (Enable),
        .PixelTick (PixelTick),
        .PixelX    (PixelX),
        .PixelY    (PixelY),
        .HSync     (HSync),
        .VSync     (VSync),
        .VideoOn   (VideoOn),
        .LineEnd   (LineEnd),
        .FrameStart(FrameStart)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Packed layout: {tick, hsync, vsync, video, lineend, framestart, x[9:0], y[9:0]}
    function automatic logic [25:0] model_out(input logic en);
        logic t, le, fs, hs, vs, vid;
        t   = en && (mdiv == CD - 1);
        le  = t && (mx == HT - 1);
        fs  = le && (my == VT - 1);
        hs  = !((mx >= HV + HF) && (mx < HV + HF + HS));
        vs  = !((my >= VV + VF) && (my < VV + VF + VS));
        vid = (mx < HV) && (my < VV);
        return {t, hs, vs, vid, le, fs, 10'(mx), 10'(my)};
    endfunction

    task automatic model_edge(input logic clr, input logic en);
        if (!clr) begin
            mdiv = 0; mx = 0; my = 0;
            m_valid = 1'b1;
        end else if (m_valid && en) begin
            if (mdiv == CD - 1) begin
                mdiv = 0;
                if (mx == HT - 1) begin
                    mx = 0;
                    if (my == VT - 1) begin
                        my = 0;
                        m_fs_cnt++;
                    end else begin
                        my = my + 1;
                    end
                end else begin
                    mx = mx + 1;
                end
            end else begin
                mdiv = mdiv + 1;
            end
        end
    endtask

    task automatic step(input logic clr, input logic en);
        logic [25:0] got;
        @(negedge clk);
        Clear_n = clr;
        Enable  = en;
        if (m_valid) sb.push_back(model_out(en));
        #1;
        if (sb.size() > 0) begin
            got = {PixelTick, HSync, VSync, VideoOn, LineEnd, FrameStart, PixelX, PixelY};
            check("outputs", 32'(got), 32'(sb.pop_front()));
            if (clr && FrameStart === 1'b1) dut_fs_cnt++;
        end
        @(posedge clk);
        model_edge(clr, en);
    endtask

    initial begin
        bit found;

        // Reset held three clocks with Enable high
        repeat (3) step(1'b0, 1'b1);
        #2;
        check("rst_x", 32'(PixelX), 32'd0);
        check("rst_y", 32'(PixelY), 32'd0);
        check("rst_hsync", 32'(HSync), 32'd1);
        check("rst_vsync", 32'(VSync), 32'd1);
        check("rst_video", 32'(VideoOn), 32'd1);

        // Two full frames free-running
        repeat (2 * HT * VT * CD) step(1'b1, 1'b1);

        // Freeze mid-line
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mx == 3 && mdiv == 0) found = 1'b1;
            else step(1'b1, 1'b1);
        end
        check("reach_freeze_point", 32'(found), 32'd1);
        repeat (10) begin
            step(1'b1, 1'b0);
            #2;
            check("freeze_x", 32'(PixelX), 32'd3);
            check("freeze_tick", 32'(PixelTick), 32'd0);
        end
        repeat (4) step(1'b1, 1'b1);
        #2;
        check("resume_x", 32'(PixelX), 32'd5);

        // Random enable gaps
        for (int i = 0; i < 400; i++) begin
            step(1'b1, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end

        // Reset during both sync pulses
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (mx == HV + HF + 1 && my == VV + VF) found = 1'b1;
            else step(1'b1, 1'b1);
        end
        check("reach_reset_point", 32'(found), 32'd1);
        step(1'b0, 1'b1);
        #2;
        check("midrst_x", 32'(PixelX), 32'd0);
        check("midrst_y", 32'(PixelY), 32'd0);
        check("midrst_hsync", 32'(HSync), 32'd1);
        check("midrst_vsync", 32'(VSync), 32'd1);

        repeat (HT * VT * CD + 10) step(1'b1, 1'b1);

        check("framestart_count", 32'(dut_fs_cnt), 32'(m_fs_cnt));
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
